// File: rtl/cms_pkg.sv
// Shared widths and the buffered beat type for the CMS trace receive path.
package cms_pkg;
  localparam int AXI_DATA_WIDTH = 512;
  localparam int XLEN           = 64;
  localparam int WORDS_PER_BEAT = AXI_DATA_WIDTH / XLEN;

  typedef struct packed {
    logic                      tlast;
    logic [AXI_DATA_WIDTH-1:0] tdata;
  } cms_beat_t;
endpackage

// File: rtl/cms_beat_fifo.sv
// Synchronous beat FIFO with registered count and full/empty flags; push and pop may coincide.
module cms_beat_fifo
  import cms_pkg::*;
#(
  parameter type beat_t     = cms_beat_t,
  parameter int  FIFO_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_push,
  input  beat_t i_din,
  input  logic  i_pop,
  output beat_t o_head,
  output logic  o_full,
  output logic  o_empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  beat_t            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !r_full;
  assign w_pop   = i_pop && !r_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Flags are computed from the pre-update count so they stay purely registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
        r_empty <= 1'b0;
        r_full  <= (r_count == CNT_W'(FIFO_DEPTH - 1));
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
        r_full  <= 1'b0;
        r_empty <= (r_count == CNT_W'(1));
      end
    end
  end
endmodule

// File: rtl/cms_axis_trace_receiver.sv
// Terminates the wide CMS trace stream, serialises each beat LSW-first and checks tlast framing.
module cms_axis_trace_receiver #(
  parameter int AXI_DATA_WIDTH = cms_pkg::AXI_DATA_WIDTH,
  parameter int OUT_WIDTH      = cms_pkg::XLEN,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      S_AXIS_tvalid,
  output logic                      S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                      S_AXIS_tlast,
  input  logic [31:0]               tlast_interval,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic                      out_beat_last,
  output logic                      out_frame_last,
  output logic [31:0]               beat_count,
  output logic [31:0]               frame_count,
  output logic [15:0]               frame_err_count,
  output logic                      frame_err
);
  localparam int WORDS  = AXI_DATA_WIDTH / OUT_WIDTH;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS - 1);

  typedef struct packed {
    logic                      tlast;
    logic [AXI_DATA_WIDTH-1:0] tdata;
  } beat_t;

  beat_t                w_din;
  beat_t                w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_accept;
  logic                 w_fire;
  logic                 w_pop;
  logic [WIDX_W-1:0]    r_widx;
  logic [OUT_WIDTH-1:0] w_words [WORDS];
  logic [OUT_WIDTH-1:0] r_hold;
  logic [31:0]          r_fbeat;
  logic [31:0]          w_n;
  logic [31:0]          w_fbeat_nxt;
  logic                 w_bad;
  logic [31:0]          r_beat_count;
  logic [31:0]          r_frame_count;
  logic [15:0]          r_err_count;
  logic                 r_err;

  // Ready depends only on registered occupancy, never on out_ready.
  assign S_AXIS_tready = en && !w_full && !rst;
  assign w_accept      = S_AXIS_tvalid && S_AXIS_tready;
  assign w_din         = {S_AXIS_tlast, S_AXIS_tdata};

  cms_beat_fifo #(
    .beat_t     (beat_t),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
    assign w_words[gi] = w_head.tdata[gi*OUT_WIDTH +: OUT_WIDTH];
  end

  assign out_valid      = !w_empty;
  assign w_fire         = out_valid && out_ready;
  assign out_beat_last  = out_valid && (r_widx == WIDX_LAST);
  assign out_frame_last = out_beat_last && w_head.tlast;
  assign w_pop          = w_fire && (r_widx == WIDX_LAST);
  assign out_data       = out_valid ? w_words[r_widx] : r_hold;

  always_ff @(posedge clk) begin
    if (rst)         r_widx <= '0;
    else if (w_fire) r_widx <= w_pop ? '0 : r_widx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_fire) r_hold <= w_words[r_widx];
  end

  // A zero interval disables checking; the frame position then restarts only on tlast.
  always_comb begin
    w_n         = r_fbeat + 32'd1;
    w_bad       = 1'b0;
    w_fbeat_nxt = w_n;
    if (tlast_interval == 32'd0) begin
      if (S_AXIS_tlast) w_fbeat_nxt = '0;
    end else if (S_AXIS_tlast) begin
      w_bad       = (w_n != tlast_interval);
      w_fbeat_nxt = '0;
    end else if (w_n == tlast_interval) begin
      w_bad       = 1'b1;
      w_fbeat_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fbeat       <= '0;
      r_beat_count  <= '0;
      r_frame_count <= '0;
      r_err_count   <= '0;
      r_err         <= 1'b0;
    end else if (w_accept) begin
      r_fbeat      <= w_fbeat_nxt;
      r_beat_count <= r_beat_count + 32'd1;
      if (S_AXIS_tlast) r_frame_count <= r_frame_count + 32'd1;
      if (w_bad) begin
        r_err <= 1'b1;
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign beat_count      = r_beat_count;
  assign frame_count     = r_frame_count;
  assign frame_err_count = r_err_count;
  assign frame_err       = r_err;
endmodule

// File: tb/tb_cms_axis_trace_receiver.sv
// Bench for cms_axis_trace_receiver: word-queue reference model with per-scenario checks.
module tb_cms_axis_trace_receiver;
  logic         clk = 1'b0;
  logic         rst, en, tvalid, tready, tlast;
  logic [511:0] tdata;
  logic [31:0]  interval;
  logic         out_valid, out_ready, obl, ofl, frame_err;
  logic [63:0]  out_data;
  logic [31:0]  beat_count, frame_count;
  logic [15:0]  err_count;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  cms_axis_trace_receiver dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .S_AXIS_tvalid   (tvalid),
    .S_AXIS_tready   (tready),
    .S_AXIS_tdata    (tdata),
    .S_AXIS_tlast    (tlast),
    .tlast_interval  (interval),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_beat_last   (obl),
    .out_frame_last  (ofl),
    .beat_count      (beat_count),
    .frame_count     (frame_count),
    .frame_err_count (err_count),
    .frame_err       (frame_err)
  );

  // Reference model: queue of pending output words plus software-visible counters.
  logic [63:0] mq_data[$];
  logic        mq_bl[$];
  logic        mq_fl[$];
  int          m_beats;
  logic [31:0] m_fbeat, m_beat_cnt, m_frame_cnt;
  int          m_err_cnt;
  logic        m_err;

  logic        o_tready, o_valid, o_bl, o_fl;
  logic [63:0] o_data;
  logic        e_tready, e_valid, e_bl, e_fl;
  logic [63:0] e_data;
  logic        acc, fire;

  task automatic model_clear();
    mq_data.delete(); mq_bl.delete(); mq_fl.delete();
    m_beats = 0; m_fbeat = 0; m_beat_cnt = 0; m_frame_cnt = 0; m_err_cnt = 0; m_err = 1'b0;
  endtask

  function automatic logic [511:0] rand_beat();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic step(input logic v, input logic [511:0] d, input logic l,
                      input logic ordy, input logic e);
    logic [31:0] n;
    logic        bad;
    tvalid = v; tdata = d; tlast = l; out_ready = ordy; en = e;
    @(negedge clk);
    o_tready = tready; o_valid = out_valid; o_data = out_data; o_bl = obl; o_fl = ofl;
    e_tready = e && !rst && (m_beats < 4);
    e_valid  = (mq_data.size() > 0);
    e_data   = e_valid ? mq_data[0] : 64'h0;
    e_bl     = e_valid ? mq_bl[0] : 1'b0;
    e_fl     = e_valid ? mq_fl[0] : 1'b0;
    acc      = v && e_tready;
    fire     = e_valid && ordy;
    if (rst) model_clear();
    else begin
      if (fire) begin
        if (mq_bl[0]) m_beats--;
        void'(mq_data.pop_front()); void'(mq_bl.pop_front()); void'(mq_fl.pop_front());
      end
      if (acc) begin
        for (int k = 0; k < 8; k++) begin
          mq_data.push_back(d[k*64 +: 64]);
          mq_bl.push_back(k == 7);
          mq_fl.push_back((k == 7) && l);
        end
        m_beats++;
        m_beat_cnt++;
        if (l) m_frame_cnt++;
        n = m_fbeat + 1;
        if (interval == 0) begin
          bad = 1'b0;
          m_fbeat = l ? 32'd0 : n;
        end else begin
          bad = l ? (n != interval) : (n == interval);
          m_fbeat = (l || n == interval) ? 32'd0 : n;
        end
        if (bad) begin
          m_err = 1'b1;
          if (m_err_cnt < 65535) m_err_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && mq_data.size() > 0; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, rand_beat(), 1'b0, 1'b1, 1'b1);
      checks++; if (o_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b exp 0", o_tready); end
    end
    rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (o_tready !== 1'b1) begin errors++; $display("FAIL reset_tready_rise got %b exp 1", o_tready); end
    checks++; if ({o_valid, o_bl, o_fl} !== 3'b000) begin errors++; $display("FAIL reset_out got %b exp 000", {o_valid, o_bl, o_fl}); end
    checks++;
    if (beat_count !== 0 || frame_count !== 0 || err_count !== 0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_counters got %0d %0d %0d %b exp 0 0 0 0", beat_count, frame_count, err_count, frame_err);
    end
  endtask

  task automatic test_single_beat();
    logic [511:0] d;
    do_reset();
    interval = 1;
    for (int k = 0; k < 8; k++) d[k*64 +: 64] = 64'(k + 1);
    step(1'b1, d, 1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 9; j++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (o_valid !== e_valid || o_bl !== e_bl || o_fl !== e_fl || (e_valid && o_data !== e_data)) begin
        errors++; $display("FAIL single_model got %b %h %b%b exp %b %h %b%b", o_valid, o_data, o_bl, o_fl, e_valid, e_data, e_bl, e_fl);
      end
      checks++;
      if (j < 8 && (o_valid !== 1'b1 || o_data !== 64'(j + 1) || o_fl !== (j == 7))) begin
        errors++; $display("FAIL single_word%0d got %b %h fl=%b exp 1 %h fl=%b", j, o_valid, o_data, o_fl, 64'(j + 1), (j == 7));
      end else if (j == 8 && o_valid !== 1'b0) begin
        errors++; $display("FAIL single_empty got %b exp 0", o_valid);
      end
    end
    checks++;
    if (beat_count !== 1 || frame_count !== 1 || frame_err !== 1'b0) begin
      errors++; $display("FAIL single_counters got %0d %0d %b exp 1 1 0", beat_count, frame_count, frame_err);
    end
  endtask

  task automatic test_framing();
    do_reset();
    interval = 4;
    for (int b = 1; b <= 5; b++) begin
      step(1'b1, rand_beat(), (b == 3), 1'b1, 1'b1);
      checks++; if (o_tready !== e_tready) begin errors++; $display("FAIL framing_tready got %b exp %b", o_tready, e_tready); end
      checks++;
      if (err_count !== 16'(m_err_cnt) || frame_err !== m_err) begin
        errors++; $display("FAIL framing_model_b%0d got %0d %b exp %0d %b", b, err_count, frame_err, m_err_cnt, m_err);
      end
      if (b == 2) begin
        checks++; if (err_count !== 0) begin errors++; $display("FAIL framing_b2 got %0d exp 0", err_count); end
      end
      for (int i = 0; i < 8; i++) begin
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (o_valid !== e_valid || o_bl !== e_bl || o_fl !== e_fl || (e_valid && o_data !== e_data)) begin
          errors++; $display("FAIL framing_word got %b %h %b%b exp %b %h %b%b", o_valid, o_data, o_bl, o_fl, e_valid, e_data, e_bl, e_fl);
        end
      end
    end
    checks++;
    if (err_count !== 1 || frame_err !== 1'b1 || frame_count !== 1 || beat_count !== 5) begin
      errors++; $display("FAIL framing_final got %0d %b %0d %0d exp 1 1 1 5", err_count, frame_err, frame_count, beat_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    interval = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, rand_beat(), 1'b0, 1'b0, 1'b1);
      checks++;
      if (o_tready !== (i < 4) || o_tready !== e_tready) begin
        errors++; $display("FAIL bp_fill%0d got %b exp %b", i, o_tready, (i < 4));
      end
    end
    checks++; if (beat_count !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", beat_count); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      checks++; if (o_tready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got %b exp 0", i, o_tready); end
      checks++;
      if (o_valid !== e_valid || o_bl !== e_bl || (e_valid && o_data !== e_data)) begin
        errors++; $display("FAIL bp_word got %b %h exp %b %h", o_valid, o_data, e_valid, e_data);
      end
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (o_tready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", o_tready); end
    drain();
  endtask

  task automatic test_random();
    logic [511:0] d;
    logic         l;
    int           sent = 0;
    int           cyc = 0;
    do_reset();
    interval = 3;
    d = rand_beat();
    l = ($urandom_range(0, 3) == 0);
    while (sent < 100 && cyc < 4000) begin
      step(1'b1, d, l, 1'($urandom_range(0, 1)), 1'b1);
      cyc++;
      checks++; if (o_tready !== e_tready) begin errors++; $display("FAIL rand_tready got %b exp %b", o_tready, e_tready); end
      checks++;
      if (o_valid !== e_valid || o_bl !== e_bl || o_fl !== e_fl || (e_valid && o_data !== e_data)) begin
        errors++; $display("FAIL rand_word got %b %h %b%b exp %b %h %b%b", o_valid, o_data, o_bl, o_fl, e_valid, e_data, e_bl, e_fl);
      end
      if (acc) begin
        sent++;
        d = rand_beat();
        l = ($urandom_range(0, 3) == 0);
      end
    end
    checks++; if (sent != 100) begin errors++; $display("FAIL rand_timeout got %0d beats exp 100", sent); end
    for (int i = 0; i < 1000 && mq_data.size() > 0; i++) begin
      step(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      checks++;
      if (o_valid !== e_valid || o_bl !== e_bl || o_fl !== e_fl || (e_valid && o_data !== e_data)) begin
        errors++; $display("FAIL rand_drain got %b %h exp %b %h", o_valid, o_data, e_valid, e_data);
      end
    end
    checks++;
    if (beat_count !== 100 || frame_count !== m_frame_cnt || err_count !== 16'(m_err_cnt) || frame_err !== m_err) begin
      errors++; $display("FAIL rand_counters got %0d %0d %0d %b exp 100 %0d %0d %b",
                         beat_count, frame_count, err_count, frame_err, m_frame_cnt, m_err_cnt, m_err);
    end
  endtask

  task automatic test_en_drop();
    int fires = 0;
    do_reset();
    interval = 0;
    step(1'b1, rand_beat(), 1'b0, 1'b0, 1'b1);
    step(1'b1, rand_beat(), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, rand_beat(), 1'b0, 1'b1, 1'b0);
      checks++; if (o_tready !== 1'b0) begin errors++; $display("FAIL en_tready got %b exp 0", o_tready); end
      checks++;
      if (o_valid !== e_valid || o_bl !== e_bl || o_fl !== e_fl || (e_valid && o_data !== e_data)) begin
        errors++; $display("FAIL en_word got %b %h %b%b exp %b %h %b%b", o_valid, o_data, o_bl, o_fl, e_valid, e_data, e_bl, e_fl);
      end
      if (o_valid === 1'b1) fires++;
    end
    checks++;
    if (fires != 16 || beat_count !== 2 || o_valid !== 1'b0) begin
      errors++; $display("FAIL en_drain got words=%0d beats=%0d valid=%b exp 16 2 0", fires, beat_count, o_valid);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    interval = 2;
    step(1'b1, rand_beat(), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL rstmid_pre_err got %b exp 1", frame_err); end
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", o_valid); end
    checks++;
    if (beat_count !== 0 || frame_count !== 0 || err_count !== 0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_counters got %0d %0d %0d %b exp 0 0 0 0", beat_count, frame_count, err_count, frame_err);
    end
    step(1'b1, rand_beat(), 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o_data !== e_data || o_bl !== 1'b0) begin
      errors++; $display("FAIL rstmid_restart got %b %h %b exp 1 %h 0", o_valid, o_data, o_bl, e_data);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0;
    out_ready = 1'b0; interval = 0;
    model_clear();
    test_reset();
    test_single_beat();
    test_framing();
    test_backpressure();
    test_random();
    test_en_drop();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
